output_limit_fifo_p: RTL
========================

Name: output_limit_fifo_p

Overview:
Single-clock, parametrised output FIFO with host-controlled output limiting. It is the next generation of the high-speed output stage and sits on the read-clock side, after the small asynchronous CDC FIFO. It adds generic word width and depth, saturating limit grants, an almost-full flag and an occupancy count. In limit mode the host reads only words already granted by a reg_output_limit pulse; in normal mode it behaves as a plain first-word-fall-through (FWFT) FIFO.

Parameters:
WIDTH, 16, data word width in bits
ADDR_MSB, 13, depth D = 2^(ADDR_MSB+1) words
LIMIT_WIDTH, 16, width of output_limit; LIMIT_MAX = 2^LIMIT_WIDTH-1 words
AF_MARGIN, 8, almost_full threshold margin; must satisfy 0 < AF_MARGIN < D

Ports:
CLK  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
din  in  WIDTH  write data
wr_en  in  1  write request
full  out  1  count == D
almost_full  out  1  count >= D-AF_MARGIN
dout  out  WIDTH  FWFT read data; valid while empty=0
rd_en  in  1  read acknowledge
empty  out  1  no readable word
mode_limit  in  1  1 = limit mode, 0 = plain FIFO
reg_output_limit  in  1  one-cycle pulse: grant a block of words
output_limit  out  LIMIT_WIDTH  size of the last grant, in words
output_limit_not_done  out  1  granted words remain unread
count  out  ADDR_MSB+2  stored words, 0..D

Behaviour:
- Reset (synchronous, rst=1 at an edge) clears the read and write pointers, count, remaining, output_limit and output_limit_not_done.
- After reset: empty=1, full=0, almost_full=0. dout is don't-care. RAM contents are not cleared.
- Reset applied mid-grant or mid-transfer discards all data and the grant.
- Storage is block RAM with a registered read, plus an FWFT output register.
- Write accepted = wr_en & ~full. Read accepted = rd_en & ~empty. Requests that are not accepted are ignored with no side effects.
- full, almost_full and empty are registered.
- A write at full is rejected even when a read is accepted in the same cycle.
- A simultaneous accepted read and write leaves count unchanged.
- Pointers wrap modulo D with no special case.
- Mode 0 latency: a word written at edge N, into an otherwise empty FIFO, gives empty=0 and dout=that word after edge N+2.
- Mode 0: remaining is forced to 0, output_limit_not_done=0, and empty reflects raw FIFO emptiness only.
- Limit mode: avail = count - remaining, which is the number of stored words not yet granted.
- On reg_output_limit with mode_limit=1 and output_limit_not_done=0:
  - grant = min(avail, LIMIT_MAX);
  - output_limit <= grant and remaining <= grant;
  - output_limit_not_done <= (grant != 0).
- avail is sampled before any same-cycle write, so a word written in the pulse cycle is not part of that grant.
- reg_output_limit is ignored while output_limit_not_done=1, and ignored in mode 0. output_limit keeps its previous value in both cases.
- Limit-mode empty = raw_empty | (remaining == 0).
- Each accepted read decrements remaining. On the read that takes remaining from 1 to 0, output_limit_not_done clears after that edge, and empty=1 from the next cycle.
- Switching mode 1->0 clears remaining and output_limit_not_done. All stored words become readable.
- Switching mode 0->1: all stored words become grantable on the next pulse.
- Arithmetic: count and remaining are unsigned. remaining never exceeds count. Saturation at LIMIT_MAX truncates only the grant size, never data.

Test Plan:
- Reset, then mode 0: write 0x0001..0x0005 on consecutive cycles -> empty falls 2 cycles after the first write; reads return 0x0001..0x0005 in order; count goes 5->0; empty=1 afterwards.
- Fill (ADDR_MSB=3, D=16, AF_MARGIN=4): 16 writes -> almost_full at count 12, full at 16. 17th write dropped. Read+write at full: write rejected, count=15.
- Limit mode: write 10 words, pulse reg_output_limit -> output_limit=10, not_done=1. Write 3 more words; reading 10 words gives empty=1, not_done=0, count=3. Second pulse -> output_limit=3.
- Pulse with an empty FIFO -> output_limit=0, not_done stays 0, empty=1. A pulse while not_done=1 leaves output_limit unchanged.
- Saturation (LIMIT_WIDTH=3): 12 words stored, pulse -> output_limit=7. Exactly 7 readable; next pulse -> 5.
- Write in the same cycle as a pulse is excluded from the grant. Switching 1->0 mid-grant (4 of 10 read) -> not_done=0 and 6+ words readable. Asserting rst mid-read -> empty=1, count=0, output_limit=0.

Source files
------------

// File: rtl/output_limit_fifo_p.sv
// Single-clock FWFT output FIFO with host-granted read limiting.
// Registered-read RAM feeds a one-word prefetch stage and the FWFT output register.
module output_limit_fifo_p #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned ADDR_MSB    = 13,
    parameter int unsigned LIMIT_WIDTH = 16,
    parameter int unsigned AF_MARGIN   = 8
) (
    input  logic                   CLK,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       din,
    input  logic                   wr_en,
    output logic                   full,
    output logic                   almost_full,
    output logic [WIDTH-1:0]       dout,
    input  logic                   rd_en,
    output logic                   empty,
    input  logic                   mode_limit,
    input  logic                   reg_output_limit,
    output logic [LIMIT_WIDTH-1:0] output_limit,
    output logic                   output_limit_not_done,
    output logic [ADDR_MSB+1:0]    count
);

    localparam int unsigned AW    = ADDR_MSB + 1;
    localparam int unsigned CW    = ADDR_MSB + 2;
    localparam int unsigned Depth = 1 << AW;

    localparam logic [CW-1:0] DepthC   = CW'(Depth);
    localparam logic [CW-1:0] AfLevel  = CW'(Depth - AF_MARGIN);
    localparam logic [31:0]   LimitMax = 32'((64'd1 << LIMIT_WIDTH) - 64'd1);

    logic [WIDTH-1:0] mem [Depth];

    logic [CW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [LIMIT_WIDTH-1:0] rem_q, rem_d;
    logic [LIMIT_WIDTH-1:0] limit_q, limit_d;
    logic                   not_done_q, not_done_d;
    logic                   valid1_q, valid1_d;
    logic                   valid2_q, valid2_d;
    logic                   empty_q, empty_d;
    logic                   full_q, full_d;
    logic                   af_q, af_d;
    logic [WIDTH-1:0]       rdata_q;
    logic [WIDTH-1:0]       dout_q;

    logic                   wr_acc, rd_acc;
    logic                   out_take, s1_move, ram_fetch;
    logic [31:0]            avail;
    logic [LIMIT_WIDTH-1:0] grant;

    always_comb begin
        wr_acc    = wr_en & ~full_q;
        rd_acc    = rd_en & ~empty_q;
        out_take  = ~valid2_q | rd_acc;
        s1_move   = valid1_q & out_take;
        ram_fetch = (wr_ptr_q != rd_ptr_q) & (~valid1_q | s1_move);

        wr_ptr_d = wr_ptr_q + CW'(wr_acc);
        rd_ptr_d = rd_ptr_q + CW'(ram_fetch);
        valid1_d = ram_fetch | (valid1_q & ~s1_move);
        valid2_d = out_take ? valid1_q : valid2_q;
        count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);

        // Ungranted words, taken before this cycle's write lands.
        avail = 32'(count_q) - 32'(rem_q) - 32'(rd_acc);
        grant = (avail > LimitMax) ? LimitMax[LIMIT_WIDTH-1:0] : avail[LIMIT_WIDTH-1:0];

        rem_d   = rem_q;
        limit_d = limit_q;
        if (!mode_limit) begin
            rem_d = '0;
        end else if (reg_output_limit && !not_done_q) begin
            rem_d   = grant;
            limit_d = grant;
        end else if (rd_acc && rem_q != '0) begin
            rem_d = rem_q - LIMIT_WIDTH'(1);
        end
        not_done_d = (rem_d != '0);

        empty_d = ~valid2_d | (mode_limit & (rem_d == '0));
        full_d  = (count_d == DepthC);
        af_d    = (count_d >= AfLevel);
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rem_q      <= '0;
            limit_q    <= '0;
            not_done_q <= 1'b0;
            valid1_q   <= 1'b0;
            valid2_q   <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            af_q       <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            limit_q    <= limit_d;
            not_done_q <= not_done_d;
            valid1_q   <= valid1_d;
            valid2_q   <= valid2_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            af_q       <= af_d;
        end
    end

    // Data path carries no reset so it maps onto block RAM and plain registers.
    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem[wr_ptr_q[AW-1:0]] <= din;
        end
        if (ram_fetch) begin
            rdata_q <= mem[rd_ptr_q[AW-1:0]];
        end
        if (s1_move) begin
            dout_q <= rdata_q;
        end
    end

    assign full                  = full_q;
    assign almost_full           = af_q;
    assign empty                 = empty_q;
    assign dout                  = dout_q;
    assign output_limit          = limit_q;
    assign output_limit_not_done = not_done_q;
    assign count                 = count_q;

endmodule
